// File: rtl/gray_counter.sv
// -----------------------------------------------------------------------------
// gray_counter
//
// Purpose:
//   Synchronous up/down counter that keeps a binary count and presents both
//   the binary value and its Gray-coded form from registers. Intended to drive
//   clock-domain-crossing pointers, where consumers need a Gray value that
//   changes by exactly one bit per counting step. Also provides a synchronous
//   load, direction control and a one-cycle wrap pulse.
//
// Parameters:
//   SIZE         counter width in bits (2..32)
//   RESET_VALUE  binary value loaded on reset (must fit in SIZE bits)
//
// Ports:
//   i_CLK         in   1     clock, all state updates on the rising edge
//   i_RST         in   1     synchronous reset, active-high
//   i_EN          in   1     count enable, one step per cycle while high
//   i_UP          in   1     direction: 1 = increment, 0 = decrement
//   i_LOAD        in   1     synchronous load of i_LOAD_VALUE
//   i_LOAD_VALUE  in   SIZE  load value (binary, or Gray when the macro below
//                            is defined)
//   o_BIN_OUT     out  SIZE  registered binary count
//   o_GRAY_OUT    out  SIZE  registered Gray form of o_BIN_OUT
//   o_WRAP        out  1     one-cycle pulse after a step that wrapped around
//
// Build option:
//   GRAY_CNT_LOAD_GRAY_EN  when defined, i_LOAD_VALUE is treated as Gray code
//                          and converted to binary before loading, so a remote
//                          Gray pointer can be re-seeded directly. When
//                          undefined, i_LOAD_VALUE is loaded unchanged.
//
// Priority at each edge: reset > load > count enable > hold.
// -----------------------------------------------------------------------------
module gray_counter #(
  parameter int          SIZE        = 4,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic            i_CLK,
  input  logic            i_RST,
  input  logic            i_EN,
  input  logic            i_UP,
  input  logic            i_LOAD,
  input  logic [SIZE-1:0] i_LOAD_VALUE,
  output logic [SIZE-1:0] o_BIN_OUT,
  output logic [SIZE-1:0] o_GRAY_OUT,
  output logic            o_WRAP
);

  localparam logic [SIZE-1:0] RESET_BIN  = RESET_VALUE[SIZE-1:0];
  localparam logic [SIZE-1:0] RESET_GRAY = RESET_BIN ^ (RESET_BIN >> 1);
  localparam logic [SIZE-1:0] ONE        = {{(SIZE-1){1'b0}}, 1'b1};
  localparam logic [SIZE-1:0] ALL_ONES   = {SIZE{1'b1}};
  localparam logic [SIZE-1:0] ALL_ZEROS  = {SIZE{1'b0}};

  logic [SIZE-1:0] load_bin;
  logic [SIZE-1:0] next_bin;
  logic [SIZE-1:0] next_gray;
  logic            next_wrap;

`ifdef GRAY_CNT_LOAD_GRAY_EN
  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above
  // it, built MSB-first as a running prefix XOR.
  always_comb begin
    load_bin = '0;
    load_bin[SIZE-1] = i_LOAD_VALUE[SIZE-1];
    for (int k = SIZE - 2; k >= 0; k--) begin
      load_bin[k] = load_bin[k+1] ^ i_LOAD_VALUE[k];
    end
  end
`else
  assign load_bin = i_LOAD_VALUE;
`endif

  // Next count and wrap flag. The wrap flag is only raised by a counting
  // step that crosses the all-ones/all-zeros boundary; a load or hold clears it.
  always_comb begin
    next_bin  = o_BIN_OUT;
    next_wrap = 1'b0;
    if (i_LOAD) begin
      next_bin = load_bin;
    end else if (i_EN) begin
      if (i_UP) begin
        next_bin  = o_BIN_OUT + ONE;
        next_wrap = (o_BIN_OUT == ALL_ONES);
      end else begin
        next_bin  = o_BIN_OUT - ONE;
        next_wrap = (o_BIN_OUT == ALL_ZEROS);
      end
    end
  end

  // Gray bank is derived from the same next value as the binary register,
  // so the two flop banks can never disagree.
  assign next_gray = next_bin ^ (next_bin >> 1);

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      o_BIN_OUT  <= RESET_BIN;
      o_GRAY_OUT <= RESET_GRAY;
      o_WRAP     <= 1'b0;
    end else begin
      o_BIN_OUT  <= next_bin;
      o_GRAY_OUT <= next_gray;
      o_WRAP     <= next_wrap;
    end
  end

endmodule

// File: tb/tb_gray_counter.sv
// -----------------------------------------------------------------------------
// tb_gray_counter
//
// Purpose:
//   Self-checking bench for gray_counter (SIZE=4). Two instances share the
//   same stimulus: one with RESET_VALUE=0 and one with RESET_VALUE=5. Expected
//   results are pushed to a scoreboard queue when stimulus is driven and
//   popped and compared one cycle later when the DUTs have updated.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_gray_counter;

  typedef struct {
    logic [3:0] bin0;
    logic [3:0] gray0;
    logic       wrap0;
    logic [3:0] bin5;
    logic [3:0] gray5;
    logic       wrap5;
  } expect_t;

  logic       clock;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] loadValue;
  logic [3:0] binOut0;
  logic [3:0] grayOut0;
  logic       wrapOut0;
  logic [3:0] binOut5;
  logic [3:0] grayOut5;
  logic       wrapOut5;

  int assertCount;
  int failCount;

  expect_t    scoreboard[$];
  logic [3:0] modelBin0;
  logic [3:0] modelBin5;
  logic [3:0] grayTable [16];
  logic [3:0] prevGray;

  gray_counter #(.SIZE(4), .RESET_VALUE(0)) dut0 (
    .i_CLK(clock), .i_RST(rst), .i_EN(en), .i_UP(up), .i_LOAD(load),
    .i_LOAD_VALUE(loadValue), .o_BIN_OUT(binOut0), .o_GRAY_OUT(grayOut0),
    .o_WRAP(wrapOut0)
  );

  gray_counter #(.SIZE(4), .RESET_VALUE(5)) dut5 (
    .i_CLK(clock), .i_RST(rst), .i_EN(en), .i_UP(up), .i_LOAD(load),
    .i_LOAD_VALUE(loadValue), .o_BIN_OUT(binOut5), .o_GRAY_OUT(grayOut5),
    .o_WRAP(wrapOut5)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Decode a load value the way the selected build interprets it.
  function automatic logic [3:0] decodeLoad(input logic [3:0] lv);
`ifdef GRAY_CNT_LOAD_GRAY_EN
    logic [3:0] b;
    b[3] = lv[3];
    b[2] = b[3] ^ lv[2];
    b[1] = b[2] ^ lv[1];
    b[0] = b[1] ^ lv[0];
    return b;
`else
    return lv;
`endif
  endfunction

  // Reference model for one edge: returns {wrap, next binary}.
  function automatic logic [4:0] modelStep(input logic [3:0] cur, input logic [3:0] rv,
                                          input logic r, input logic ld,
                                          input logic e, input logic u,
                                          input logic [3:0] lv);
    int n;
    if (r) return {1'b0, rv};
    if (ld) return {1'b0, decodeLoad(lv)};
    if (e) begin
      n = u ? int'(cur) + 1 : int'(cur) - 1;
      if (n > 15) return {1'b1, 4'd0};
      if (n < 0) return {1'b1, 4'd15};
      return {1'b0, n[3:0]};
    end
    return {1'b0, cur};
  endfunction

  // Drive one cycle of stimulus, push the expectation, then compare after
  // the edge that consumes it.
  task automatic applyStimulus(input logic r, input logic ld, input logic e,
                               input logic u, input logic [3:0] lv);
    expect_t    exp;
    expect_t    got;
    logic [4:0] s0;
    logic [4:0] s5;
    rst = r; load = ld; en = e; up = u; loadValue = lv;
    s0 = modelStep(modelBin0, 4'd0, r, ld, e, u, lv);
    s5 = modelStep(modelBin5, 4'd5, r, ld, e, u, lv);
    modelBin0 = s0[3:0];
    modelBin5 = s5[3:0];
    exp.bin0 = s0[3:0]; exp.gray0 = grayTable[s0[3:0]]; exp.wrap0 = s0[4];
    exp.bin5 = s5[3:0]; exp.gray5 = grayTable[s5[3:0]]; exp.wrap5 = s5[4];
    scoreboard.push_back(exp);
    @(posedge clock);
    #1;
    got = scoreboard.pop_front();
    checkOutput("bin", 32'(binOut0), 32'(got.bin0));
    checkOutput("gray", 32'(grayOut0), 32'(got.gray0));
    checkOutput("wrap", 32'(wrapOut0), 32'(got.wrap0));
    checkOutput("bin_rv5", 32'(binOut5), 32'(got.bin5));
    checkOutput("gray_rv5", 32'(grayOut5), 32'(got.gray5));
    checkOutput("wrap_rv5", 32'(wrapOut5), 32'(got.wrap5));
  endtask

  initial begin
    grayTable = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                  4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    assertCount = 0;
    failCount = 0;
    modelBin0 = 4'd0;
    modelBin5 = 4'd5;
    rst = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; loadValue = 4'd0;
    #1;

    $display("[TB] reset");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    checkOutput("reset_gray_rv5_const", 32'(grayOut5), 32'h7);

    $display("[TB] count up 17 steps");
    prevGray = grayOut0;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
      checkOutput("gray_one_bit_step", 32'($countones(grayOut0 ^ prevGray)), 32'd1);
      prevGray = grayOut0;
    end

    $display("[TB] count down through zero then hold");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    checkOutput("down_wrap_gray_const", 32'(grayOut0), 32'h8);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);

    $display("[TB] load");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'd9);
`ifndef GRAY_CNT_LOAD_GRAY_EN
    checkOutput("load9_gray_const", 32'(grayOut0), 32'hD);
`endif
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd15);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
`ifdef GRAY_CNT_LOAD_GRAY_EN
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'b1101);
    checkOutput("gray_load_bin_const", 32'(binOut0), 32'd9);
`endif

    $display("[TB] reset beats load and enable mid-count");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'd3);

    $display("[TB] random traffic");
    for (int i = 0; i < 60; i++) begin
      applyStimulus(($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0),
                    1'($urandom_range(0, 1) | $urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    checkOutput("scoreboard_empty", 32'(scoreboard.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
